// File: rtl/reg_file_wb.sv
// Decode-stage integer register file fed by the write-back stage.
// Decodes the write enable from the WB opcode, forwards same-cycle writes and counts retirements.
module reg_file_wb #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned CNT_W  = 64,
    parameter int unsigned BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_valid,
    input  logic [6:0]       opcode_WB,
    input  logic [AW-1:0]    rd_WB,
    input  logic [XLEN-1:0]  RWrdata,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic             reg_we,
    output logic [CNT_W-1:0] retired_count
);

    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpOpImm = 7'b0010011;
    localparam logic [6:0] OpOp    = 7'b0110011;

    if (AW != $clog2(NREGS)) begin : gen_aw_check
        $error("AW must equal clog2(NREGS)");
    end

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] retired_d;
    logic             writes_rd;

    always_comb begin
        case (opcode_WB)
            OpLui, OpAuipc, OpJal, OpJalr, OpLoad, OpOpImm, OpOp: writes_rd = 1'b1;
            default:                                              writes_rd = 1'b0;
        endcase
    end

    assign reg_we = wb_valid & writes_rd & (rd_WB != '0);

    // Stores, branches and illegal opcodes still retire.
    always_comb begin
        retired_d = retired_q;
        if (wb_valid) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // Async reset wins over any write presented in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
            retired_q <= '0;
        end else begin
            if (reg_we) begin
                regs_q[rd_WB] <= RWrdata;
            end
            retired_q <= retired_d;
        end
    end

    always_comb begin
        rs1_data = '0;
        if (rs1_addr != '0) begin
            if ((BYPASS != 0) && reg_we && (rd_WB == rs1_addr)) begin
                rs1_data = RWrdata;
            end else begin
                rs1_data = regs_q[rs1_addr];
            end
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_addr != '0) begin
            if ((BYPASS != 0) && reg_we && (rd_WB == rs2_addr)) begin
                rs2_data = RWrdata;
            end else begin
                rs2_data = regs_q[rs2_addr];
            end
        end
    end

    assign retired_count = retired_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Bench for reg_file_wb: directed table, hand-written corner sequences and a random run
// against an array-based architectural model, over bypassing, non-bypassing and 4-bit-counter builds.
module tb_reg_file_wb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_valid = 1'b0;
    logic [6:0]  opcode_WB = '0;
    logic [4:0]  rd_WB = '0;
    logic [31:0] RWrdata = '0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;

    logic [31:0] b1_rs1, b1_rs2, b0_rs1, b0_rs2, c4_rs1, c4_rs2;
    logic        b1_we, b0_we, c4_we;
    logic [63:0] b1_cnt, b0_cnt;
    logic [3:0]  c4_cnt;

    always #5 clk = ~clk;

    reg_file_wb dut_b1 (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .opcode_WB(opcode_WB), .rd_WB(rd_WB),
        .RWrdata(RWrdata), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(b1_rs1),
        .rs2_data(b1_rs2), .reg_we(b1_we), .retired_count(b1_cnt)
    );

    reg_file_wb #(.BYPASS(0)) dut_b0 (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .opcode_WB(opcode_WB), .rd_WB(rd_WB),
        .RWrdata(RWrdata), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(b0_rs1),
        .rs2_data(b0_rs2), .reg_we(b0_we), .retired_count(b0_cnt)
    );

    reg_file_wb #(.CNT_W(4)) dut_c4 (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .opcode_WB(opcode_WB), .rd_WB(rd_WB),
        .RWrdata(RWrdata), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(c4_rs1),
        .rs2_data(c4_rs2), .reg_we(c4_we), .retired_count(c4_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Architectural model: register contents and number of retirements so far.
    logic [31:0] mregs [32];
    longint unsigned mcnt;

    logic [6:0] wr_ops [7] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                               7'b0000011, 7'b0010011, 7'b0110011};
    logic [6:0] op_pool [12] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                 7'b0000011, 7'b0010011, 7'b0110011, 7'b0100011,
                                 7'b1100011, 7'b1110011, 7'b0001111, 7'b0000000};

    function automatic bit is_writer(input logic [6:0] op);
        foreach (wr_ops[k]) if (wr_ops[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a, input bit byp,
                                               input bit we, input logic [4:0] rd,
                                               input logic [31:0] d);
        if (a == 0) return 32'h0;
        if (byp && we && rd == a) return d;
        return mregs[a];
    endfunction

    typedef struct packed {
        logic        valid;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        we;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [63:0] cnt;
    } vec_t;

    vec_t tbl [8];

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rd,
                         input logic [31:0] d, input logic [4:0] a1, input logic [4:0] a2);
        wb_valid = v; opcode_WB = op; rd_WB = rd; RWrdata = d; rs1_addr = a1; rs2_addr = a2;
    endtask

    initial begin
        tbl = '{
            '{1'b1, 7'b0110011, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b1, 32'hDEADBEEF, 32'h0, 64'd1},
            '{1'b1, 7'b0100011, 5'd7, 32'h00001234, 5'd7, 5'd5, 1'b0, 32'h0, 32'hDEADBEEF, 64'd2},
            '{1'b1, 7'b1100011, 5'd7, 32'h00001234, 5'd7, 5'd7, 1'b0, 32'h0, 32'h0, 64'd3},
            '{1'b1, 7'b0010011, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 64'd4},
            '{1'b0, 7'b0000011, 5'd3, 32'h00000055, 5'd3, 5'd5, 1'b0, 32'h0, 32'hDEADBEEF, 64'd4},
            '{1'b1, 7'b0110111, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5,
              64'd5},
            '{1'b1, 7'b1110011, 5'd9, 32'h00000000, 5'd9, 5'd5, 1'b0, 32'hA5A5A5A5, 32'hDEADBEEF,
              64'd6},
            '{1'b0, 7'b0110011, 5'd1, 32'h00000000, 5'd1, 5'd9, 1'b0, 32'h0, 32'hA5A5A5A5, 64'd6}
        };

        // Reset asserted before any clock edge must clear everything asynchronously.
        drive(1'b0, 7'h0, 5'd0, 32'h0, 5'd5, 5'd9);
        #1 rst = 1'b1;
        #1;
        chk("reset_rs1", {32'h0, b1_rs1}, 64'h0);
        chk("reset_rs2", {32'h0, b1_rs2}, 64'h0);
        chk("reset_cnt", b1_cnt, 64'h0);
        chk("reset_cnt4", {60'h0, c4_cnt}, 64'h0);
        rst = 1'b0;
        for (int a = 1; a < 32; a++) begin
            rs1_addr = 5'(a);
            rs2_addr = 5'(a);
            #1;
            chk($sformatf("reset_x%0d", a), {b1_rs1, b1_rs2}, 64'h0);
        end

        @(posedge clk); #1;
        foreach (tbl[i]) begin
            drive(tbl[i].valid, tbl[i].op, tbl[i].rd, tbl[i].data, tbl[i].a1, tbl[i].a2);
            #1;
            chk($sformatf("tbl%0d_we", i), {63'h0, b1_we}, {63'h0, tbl[i].we});
            chk($sformatf("tbl%0d_rs1", i), {32'h0, b1_rs1}, {32'h0, tbl[i].r1});
            chk($sformatf("tbl%0d_rs2", i), {32'h0, b1_rs2}, {32'h0, tbl[i].r2});
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_cnt", i), b1_cnt, tbl[i].cnt);
        end

        // Without bypass the old x9 is visible until the edge, the new one after it.
        drive(1'b1, 7'b1101111, 5'd9, 32'h11111111, 5'd9, 5'd9);
        #1;
        chk("nobyp_before", {32'h0, b0_rs1}, 64'hA5A5A5A5);
        chk("byp_before", {b1_rs1, b1_rs2}, 64'h11111111_11111111);
        @(posedge clk); #1;
        chk("nobyp_after", {b0_rs1, b0_rs2}, 64'h11111111_11111111);

        // Random run against the model.
        drive(1'b0, 7'h0, 5'd0, 32'h0, 5'd0, 5'd0);
        rst = 1'b1; #1 rst = 1'b0;
        foreach (mregs[k]) mregs[k] = 32'h0;
        mcnt = 0;
        @(posedge clk); #1;
        for (int n = 0; n < 400; n++) begin
            logic [6:0]  op;
            logic [4:0]  rd;
            logic [31:0] d;
            bit          v, we;
            v  = ($urandom_range(0, 3) != 0);
            op = ($urandom_range(0, 5) == 0) ? 7'($urandom) : op_pool[$urandom_range(0, 11)];
            rd = 5'($urandom);
            d  = $urandom;
            drive(v, op, rd, d,
                  ($urandom_range(0, 2) == 0) ? rd : 5'($urandom),
                  ($urandom_range(0, 2) == 0) ? rd : 5'($urandom));
            we = v && is_writer(op) && (rd != 0);
            #1;
            chk("rnd_we", {62'h0, b1_we, b0_we}, {62'h0, we, we});
            chk("rnd_b1_rs", {b1_rs1, b1_rs2},
                {model_read(rs1_addr, 1'b1, we, rd, d), model_read(rs2_addr, 1'b1, we, rd, d)});
            chk("rnd_b0_rs", {b0_rs1, b0_rs2},
                {model_read(rs1_addr, 1'b0, we, rd, d), model_read(rs2_addr, 1'b0, we, rd, d)});
            @(posedge clk); #1;
            if (we) mregs[rd] = d;
            if (v) mcnt++;
            chk("rnd_cnt", b1_cnt, mcnt);
            chk("rnd_cnt4", {60'h0, c4_cnt}, mcnt % 16);
        end

        // Mid-stream async reset: everything reads zero before the next edge.
        drive(1'b0, 7'h0, 5'd0, 32'h0, 5'd0, 5'd0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_cnt", b1_cnt, 64'h0);
        for (int a = 1; a < 32; a++) begin
            rs1_addr = 5'(a);
            #0.1;
            chk($sformatf("midrst_x%0d", a), {32'h0, b1_rs1}, 64'h0);
        end

        // A write presented while reset is held is dropped.
        @(posedge clk); #1;
        drive(1'b1, 7'b0110011, 5'd4, 32'h0000CAFE, 5'd4, 5'd4);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 7'h0, 5'd0, 32'h0, 5'd4, 5'd4);
        #1;
        chk("rstwr_drop", {b1_rs1, b0_rs1}, 64'h0);
        chk("rstwr_cnt", b1_cnt, 64'h0);

        // Counter wrap on the 4-bit build.
        @(posedge clk); #1;
        drive(1'b1, 7'b0100011, 5'd2, 32'h0, 5'd2, 5'd0);
        repeat (15) @(posedge clk);
        #1;
        chk("wrap_15", {60'h0, c4_cnt}, 64'd15);
        @(posedge clk); #1;
        chk("wrap_0", {60'h0, c4_cnt}, 64'd0);
        chk("wrap_wide", b1_cnt, 64'd16);
        chk("wrap_store_nowrite", {32'h0, b1_rs1}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
